ps2_morse_keyer: RTL and testbench
==================================

PS2_MORSE_KEYER -- requirements
Module: ps2_morse_keyer

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 10_000_000: clock cycles per Morse time unit (dot length), legal range 2 to 2^24-1.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: character buffer depth, power of two, legal range 2 to 64.
REQ-003 SHALL have parameter TONE_HALF_PERIOD, default 12_500: clock cycles per tone_out half period, legal minimum 1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  8  ASCII character from the PS/2 decode path.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  high when a character can be accepted; equals NOT fifo_full.
REQ-009 morse_out  output  1  keyed Morse level; 1 means mark.
REQ-010 tone_out  output  1  square-wave sidetone, gated by morse_out.
REQ-011 busy  output  1  high when the FIFO is non-empty or any symbol or gap is in progress.
REQ-012 fifo_full, fifo_empty  output  1 each  buffer status flags.
REQ-013 err_char  output  1  one-cycle pulse when an unsupported character is accepted.

Function
REQ-014 Transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; with in_valid=1 and in_ready=0 the character SHALL be neither stored nor flagged.
REQ-015 Supported characters: 'A'-'Z' (0x41-0x5A), 'a'-'z' (0x61-0x7A, mapped to uppercase), '0'-'9' (0x30-0x39), space (0x20); all other accepted bytes SHALL be discarded, leaving the FIFO unchanged, and err_char SHALL pulse for exactly one cycle.
REQ-016 The FIFO SHALL store FIFO_DEPTH entries, with wrap-around pointers and an occupancy count of width clog2(FIFO_DEPTH)+1; a write and a read on the same edge SHALL leave the count unchanged, including when the FIFO is full.
REQ-017 Encoding SHALL be the ITU Morse table, at most 5 elements per character, held as a 3-bit length and a 5-bit pattern sent MSB-first, where 1 = dash and 0 = dot.
REQ-018 FSM states SHALL be IDLE, FETCH, MARK, ELEM_GAP, CHAR_GAP and WORD_GAP.
REQ-019 IDLE -> FETCH when the FIFO is non-empty; FETCH pops one entry and decodes it in one cycle, then goes to MARK for a letter or digit, or to WORD_GAP for a space.
REQ-020 MARK: morse_out=1 for exactly UNIT_CYCLES cycles (dot) or 3*UNIT_CYCLES cycles (dash); then go to ELEM_GAP if elements remain, otherwise to CHAR_GAP.
REQ-021 ELEM_GAP: morse_out=0 for exactly UNIT_CYCLES cycles, then return to MARK.
REQ-022 CHAR_GAP: morse_out=0 for exactly 3*UNIT_CYCLES cycles, then go to FETCH if the FIFO is non-empty, else to IDLE.
REQ-023 WORD_GAP: morse_out=0 for exactly 4*UNIT_CYCLES cycles, so that letter-space-letter gives 7 units; then go to FETCH or IDLE as in REQ-022; consecutive spaces SHALL each add 4 units.
REQ-024 Latency: for a character accepted on edge T with the FSM in IDLE and the FIFO empty, morse_out SHALL rise on edge T+2.
REQ-025 The unit counter SHALL be 24 bits; the 3x and 4x durations SHALL count units, not multiplied cycle counts, so no overflow occurs.
REQ-026 tone_out SHALL toggle every TONE_HALF_PERIOD cycles while morse_out=1; it SHALL be 0 and its divider cleared whenever morse_out=0.
REQ-027 busy SHALL drop in the cycle the FSM re-enters IDLE with the FIFO empty.
REQ-028 Accepting characters during transmission SHALL NOT alter the timing of the current character.

Reset
REQ-029 While rst_n=0, immediately and without waiting for clk: FSM=IDLE, FIFO emptied, all counters cleared, morse_out=0, tone_out=0, busy=0, err_char=0, fifo_full=0, fifo_empty=1, in_ready=1.
REQ-030 Reset asserted mid-element SHALL abort the character and discard the FIFO contents; after release, operation SHALL resume from IDLE on the first edge.

Verification (UNIT_CYCLES=4, FIFO_DEPTH=4, TONE_HALF_PERIOD=2)
REQ-031 Send 'E' (0x45) when idle -> morse_out high 4 cycles starting T+2, then low 12 cycles; busy falls at the end of the low period.
REQ-032 Send 'a' (0x61) -> morse_out pattern high 4, low 4, high 12, low 12; tone_out toggles every 2 cycles only while morse_out=1.
REQ-033 Send "E E" (0x45,0x20,0x45) back-to-back -> low interval between the two marks is exactly 28 cycles.
REQ-034 Hold in_valid=1 with six letters while the keyer is busy -> in_ready drops after the FIFO holds 4 entries, the extra characters are not accepted, and all accepted characters are sent in order.
REQ-035 Send 0x23 '#' -> err_char pulses for one cycle, fifo_empty stays 1, and morse_out stays 0.
REQ-036 Assert rst_n=0 during the dash of 'T' -> morse_out and tone_out go 0 asynchronously and fifo_empty=1; after release, 'E' transmits per REQ-031.

Source files
------------

// File: rtl/ps2_morse_keyer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_morse_keyer: buffers ASCII characters and keys them out as ITU Morse  |
// | with a gated square-wave sidetone.                                        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ps2_morse_keyer #(
  parameter int UNIT_CYCLES      = 10_000_000,
  parameter int FIFO_DEPTH       = 16,
  parameter int TONE_HALF_PERIOD = 12_500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       morse_out,
  output logic       tone_out,
  output logic       busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       err_char
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TONE_HALF_PERIOD > 1) ? $clog2(TONE_HALF_PERIOD) : 1;

  localparam logic [23:0]   c_UNIT_LAST   = 24'(UNIT_CYCLES - 1);
  localparam logic [23:0]   c_UNIT_PENULT = 24'(UNIT_CYCLES - 2);
  localparam logic [CW-1:0] c_DEPTH       = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] c_TONE_LAST   = TW'(TONE_HALF_PERIOD - 1);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_FETCH    = 3'd1;
  localparam logic [2:0] c_MARK     = 3'd2;
  localparam logic [2:0] c_ELEM_GAP = 3'd3;
  localparam logic [2:0] c_CHAR_GAP = 3'd4;
  localparam logic [2:0] c_WORD_GAP = 3'd5;

  // {length[2:0], pattern[4:0]}: pattern left-aligned, 1 = dash; length 0 = space
  function automatic logic [7:0] f_encode(input logic [7:0] ch);
    logic [7:0] code;
    case (ch)
      8'h41: code = {3'd2, 5'b01000};   8'h42: code = {3'd4, 5'b10000};
      8'h43: code = {3'd4, 5'b10100};   8'h44: code = {3'd3, 5'b10000};
      8'h45: code = {3'd1, 5'b00000};   8'h46: code = {3'd4, 5'b00100};
      8'h47: code = {3'd3, 5'b11000};   8'h48: code = {3'd4, 5'b00000};
      8'h49: code = {3'd2, 5'b00000};   8'h4A: code = {3'd4, 5'b01110};
      8'h4B: code = {3'd3, 5'b10100};   8'h4C: code = {3'd4, 5'b01000};
      8'h4D: code = {3'd2, 5'b11000};   8'h4E: code = {3'd2, 5'b10000};
      8'h4F: code = {3'd3, 5'b11100};   8'h50: code = {3'd4, 5'b01100};
      8'h51: code = {3'd4, 5'b11010};   8'h52: code = {3'd3, 5'b01000};
      8'h53: code = {3'd3, 5'b00000};   8'h54: code = {3'd1, 5'b10000};
      8'h55: code = {3'd3, 5'b00100};   8'h56: code = {3'd4, 5'b00010};
      8'h57: code = {3'd3, 5'b01100};   8'h58: code = {3'd4, 5'b10010};
      8'h59: code = {3'd4, 5'b10110};   8'h5A: code = {3'd4, 5'b11000};
      8'h30: code = {3'd5, 5'b11111};   8'h31: code = {3'd5, 5'b01111};
      8'h32: code = {3'd5, 5'b00111};   8'h33: code = {3'd5, 5'b00011};
      8'h34: code = {3'd5, 5'b00001};   8'h35: code = {3'd5, 5'b00000};
      8'h36: code = {3'd5, 5'b10000};   8'h37: code = {3'd5, 5'b11000};
      8'h38: code = {3'd5, 5'b11100};   8'h39: code = {3'd5, 5'b11110};
      default: code = 8'h00;
    endcase
    return code;
  endfunction

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_state, w_next_state;
  logic [23:0]   r_cyc;
  logic [2:0]    r_units;
  logic [4:0]    r_pat;
  logic [2:0]    r_left;
  logic [TW-1:0] r_div;
  logic          r_tone;
  logic          r_err;

  logic       w_full, w_empty, w_accept, w_supported, w_push, w_pop, w_lower;
  logic [7:0] w_wdata, w_code;
  logic [2:0] w_target;
  logic       w_unit_end, w_last, w_penult;

  assign w_full      = (r_count == c_DEPTH);
  assign w_empty     = (r_count == '0);
  assign w_accept    = in_valid && !w_full;
  assign w_lower     = (in_data >= 8'h61) && (in_data <= 8'h7A);
  assign w_supported = ((in_data >= 8'h41) && (in_data <= 8'h5A)) || w_lower ||
                       ((in_data >= 8'h30) && (in_data <= 8'h39)) || (in_data == 8'h20);
  assign w_wdata     = w_lower ? (in_data - 8'h20) : in_data;
  assign w_push      = w_accept && w_supported;
  assign w_pop       = (r_state == c_FETCH);
  assign w_code      = f_encode(r_mem[r_rd_ptr]);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_accept && !w_supported;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Durations are counted in whole units so 3x/4x never overflow the 24-bit cycle counter.
  always_comb begin
    w_target = 3'd1;
    case (r_state)
      c_MARK:     w_target = r_pat[4] ? 3'd3 : 3'd1;
      c_CHAR_GAP: w_target = 3'd3;
      c_WORD_GAP: w_target = 3'd4;
      default:    w_target = 3'd1;
    endcase
  end

  assign w_unit_end = (r_cyc == c_UNIT_LAST);
  assign w_last     = w_unit_end && (r_units == (w_target - 3'd1));
  assign w_penult   = (r_cyc == c_UNIT_PENULT) && (r_units == (w_target - 3'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next_state;
  end

  // A queued character's FETCH cycle stands in for the final gap cycle, so
  // inter-character spacing stays an exact multiple of the unit.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:     if (!w_empty) w_next_state = c_FETCH;
      c_FETCH:    w_next_state = (w_code[7:5] == 3'd0) ? c_WORD_GAP : c_MARK;
      c_MARK:     if (w_last) w_next_state = (r_left > 3'd1) ? c_ELEM_GAP : c_CHAR_GAP;
      c_ELEM_GAP: if (w_last) w_next_state = c_MARK;
      c_CHAR_GAP, c_WORD_GAP: begin
        if (!w_empty && (w_penult || w_last)) w_next_state = c_FETCH;
        else if (w_last)                      w_next_state = c_IDLE;
      end
      default:    w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    morse_out  = (r_state == c_MARK);
    tone_out   = morse_out && r_tone;
    busy       = (r_state != c_IDLE) || !w_empty;
    in_ready   = !w_full;
    fifo_full  = w_full;
    fifo_empty = w_empty;
    err_char   = r_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc   <= '0;
      r_units <= '0;
      r_pat   <= '0;
      r_left  <= '0;
    end else begin
      if ((r_state != w_next_state) || (r_state == c_IDLE)) begin
        r_cyc   <= '0;
        r_units <= '0;
      end else if (w_unit_end) begin
        r_cyc   <= '0;
        r_units <= r_units + 3'd1;
      end else begin
        r_cyc <= r_cyc + 24'd1;
      end
      if (r_state == c_FETCH) begin
        r_pat  <= w_code[4:0];
        r_left <= w_code[7:5];
      end else if ((r_state == c_MARK) && w_last) begin
        r_pat  <= {r_pat[3:0], 1'b0};
        r_left <= r_left - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_tone <= 1'b0;
    end else if (r_state == c_MARK) begin
      if (r_div == c_TONE_LAST) begin
        r_div  <= '0;
        r_tone <= !r_tone;
      end else begin
        r_div <= r_div + TW'(1);
      end
    end else begin
      r_div  <= '0;
      r_tone <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_morse_keyer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for ps2_morse_keyer: timeline model of the keyed waveform plus literal pins.
module tb_ps2_morse_keyer;
  localparam int U   = 4;
  localparam int D   = 4;
  localparam int THP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, morse_out, tone_out, busy, fifo_full, fifo_empty, err_char;

  ps2_morse_keyer #(.UNIT_CYCLES(U), .FIFO_DEPTH(D), .TONE_HALF_PERIOD(THP)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .morse_out(morse_out), .tone_out(tone_out), .busy(busy),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .err_char(err_char)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  string LET [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                      "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string DIG [10] = '{"-----", ".----", "..---", "...--", "....-",
                      ".....", "-....", "--...", "---..", "----."};

  function automatic bit supported(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A) ||
           (c >= 8'h30 && c <= 8'h39) || (c == 8'h20);
  endfunction

  function automatic string code_of(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    if (u == 8'h20) return "";
    if (u >= 8'h30 && u <= 8'h39) return DIG[u - 8'h30];
    return LET[u - 8'h41];
  endfunction

  // Timeline of future samples: bit0 = expected keying level, bit1 = FIFO pop slot.
  bit [1:0] q_tl [$];
  int       m_count = 0;
  bit       pend_pop = 0;
  int       mark_k = 0;
  bit       e_morse = 0, e_tone = 0, e_busy = 0, e_err = 0;

  task automatic model_accept(input logic [7:0] c);
    string    s;
    bit [1:0] bits [$];
    int       L;
    s = code_of(c);
    L = q_tl.size();
    if (c == 8'h20) begin
      repeat (4*U) bits.push_back(2'b00);
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        repeat ((s[i] == 8'h2D) ? 3*U : U) bits.push_back(2'b01);
        if (i < s.len() - 1) repeat (U) bits.push_back(2'b00);
      end
      repeat (3*U) bits.push_back(2'b00);
    end
    if (L == 0) begin
      q_tl.push_back(2'b00);
      q_tl.push_back(2'b10);
    end else if (L == 1) begin
      q_tl.push_back(2'b10);
    end else begin
      q_tl[L-1] = q_tl[L-1] | 2'b10;
    end
    foreach (bits[i]) q_tl.push_back(bits[i]);
  endtask

  task automatic model_step();
    int       pre;
    bit [1:0] s;
    pre = m_count;
    if (pend_pop) begin
      m_count--;
      pend_pop = 0;
    end
    e_err = 0;
    if (in_valid && pre < D) begin
      if (supported(in_data)) begin
        m_count++;
        model_accept(in_data);
      end else begin
        e_err = 1;
      end
    end
    if (q_tl.size() > 0) begin
      s = q_tl.pop_front();
      e_morse = s[0];
      e_busy = 1;
      pend_pop = s[1];
    end else begin
      e_morse = 0;
      e_busy = (m_count > 0);
    end
    if (e_morse) begin
      e_tone = ((mark_k / THP) % 2) == 1;
      mark_k++;
    end else begin
      e_tone = 0;
      mark_k = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q_tl.delete();
        m_count = 0;
        pend_pop = 0;
        mark_k = 0;
        e_morse = 0; e_tone = 0; e_busy = 0; e_err = 0;
      end else begin
        model_step();
      end
      #1;
      chk("morse_out",  morse_out,  e_morse);
      chk("tone_out",   tone_out,   e_tone);
      chk("busy",       busy,       e_busy);
      chk("err_char",   err_char,   e_err);
      chk("fifo_full",  fifo_full,  m_count == D);
      chk("fifo_empty", fifo_empty, m_count == 0);
      chk("in_ready",   in_ready,   m_count < D);
    end
  end

  int runs [$];
  int eq [$];
  int tone_hi, tone_bad, marks, ready_lo;

  task automatic send_seq(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = s[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Run lengths of morse_out from the cycle after the first accept until busy drops.
  task automatic measure();
    int lvl, len, n;
    bit done;
    lvl = 0; len = 0; n = 0; done = 0;
    runs.delete();
    tone_hi = 0; tone_bad = 0; marks = 0; ready_lo = 0;
    wait (in_valid);
    @(posedge clk);
    while (!done && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) begin
        done = 1;
      end else begin
        if (int'(morse_out) == lvl) begin
          len++;
        end else begin
          runs.push_back(len);
          lvl = int'(morse_out);
          len = 1;
          if (morse_out) marks++;
        end
        if (tone_out) tone_hi++;
        if (tone_out && !morse_out) tone_bad++;
        if (!in_ready) ready_lo++;
      end
    end
    if (done) runs.push_back(len);
    chk("measure_timeout", done, 1);
  endtask

  task automatic chk_runs(input string nm, input int exp_q [$]);
    chk({nm, "_nruns"}, runs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < runs.size(); i++)
      chk($sformatf("%s_run%0d", nm, i), runs[i], exp_q[i]);
  endtask

  initial begin
    int err_hi, morse_hi, empty_lo;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fork send_seq("E"); measure(); join
    eq = '{1, 4, 12};
    chk_runs("E", eq);

    fork send_seq("a"); measure(); join
    eq = '{1, 4, 4, 12, 12};
    chk_runs("a", eq);
    chk("a_tone_high_cycles", tone_hi, 8);
    chk("a_tone_outside_mark", tone_bad, 0);

    fork send_seq("E E"); measure(); join
    eq = '{1, 4, 28, 4, 12};
    chk_runs("E_sp_E", eq);

    fork
      begin
        send_seq("T");
        repeat (3) @(negedge clk);
        send_seq("A5C9EF");
      end
      measure();
    join
    chk("full_ready_dropped", ready_lo > 0, 1);
    chk("full_mark_count", marks, 17);

    err_hi = 0; morse_hi = 0; empty_lo = 0;
    fork
      send_seq("#");
      begin
        wait (in_valid);
        repeat (6) begin
          @(posedge clk);
          #1;
          err_hi   += int'(err_char);
          morse_hi += int'(morse_out);
          empty_lo += int'(!fifo_empty);
        end
      end
    join
    chk("hash_err_pulses", err_hi, 1);
    chk("hash_morse_high", morse_hi, 0);
    chk("hash_fifo_nonempty", empty_lo, 0);

    send_seq("TE");
    repeat (3) @(negedge clk);
    chk("pre_rst_morse", morse_out, 1);
    chk("pre_rst_tone", tone_out, 1);
    chk("pre_rst_fifo_empty", fifo_empty, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_morse", morse_out, 0);
    chk("rst_tone", tone_out, 0);
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    fork send_seq("E"); measure(); join
    eq = '{1, 4, 12};
    chk_runs("post_rst_E", eq);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #300_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
